// File: rtl/line_dispatcher_if.sv
// Command-side bundle between the vector front end, the line dispatcher and the rasterizer.
// master is the dispatcher's view; slave is the view of the logic surrounding it.
interface line_dispatcher_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 13,
  parameter int unsigned CNTW  = 16
);
  logic                   push;
  logic signed [CW-1:0]   inStartX;
  logic signed [CW-1:0]   inEndX;
  logic signed [CW-1:0]   inStartY;
  logic signed [CW-1:0]   inEndY;
  logic [3:0]             inColor;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   frameEnd;
  logic                   frameDone;
  logic [CNTW-1:0]        linesDrawn;
  logic signed [CW-1:0]   startX;
  logic signed [CW-1:0]   endX;
  logic signed [CW-1:0]   startY;
  logic signed [CW-1:0]   endY;
  logic [3:0]             lineColor;
  logic                   readyIn;
  logic                   rastReady;
  logic                   done;

  modport master (
    input  push, inStartX, inEndX, inStartY, inEndY, inColor, frameEnd, rastReady, done,
    output full, empty, count, overflow, frameDone, linesDrawn,
           startX, endX, startY, endY, lineColor, readyIn
  );

  modport slave (
    output push, inStartX, inEndX, inStartY, inEndY, inColor, frameEnd, rastReady, done,
    input  full, empty, count, overflow, frameDone, linesDrawn,
           startX, endX, startY, endY, lineColor, readyIn
  );
endinterface

// File: rtl/line_dispatcher.sv
// Queues line commands in a circular FIFO and hands them to the rasterizer one at a time,
// waiting for each line's done pulse; also signals when a terminated frame has fully drained.
module line_dispatcher #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 13,
  parameter int unsigned CNTW  = 16
) (
  input logic               clk,
  input logic               rst,
  line_dispatcher_if.master bus
);
  localparam int unsigned     PTRW     = $clog2(DEPTH);
  localparam int unsigned     EW       = 4 * CW + 4;
  localparam logic [PTRW:0]   FULL_CNT = (PTRW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pend_q, pend_d;
  logic [CNTW-1:0] lines_q, lines_d;
  logic [EW-1:0]   hold_q, hold_d;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   wr_entry;
  logic            push_ok;
  logic            pop;
  logic            frame_done;

  // Entry layout: {colour, endY, startY, endX, startX}
  assign wr_entry   = {bus.inColor, bus.inEndY, bus.inStartY, bus.inEndX, bus.inStartX};
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok    = bus.push && (count_q != FULL_CNT);
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign frame_done = pend_q && (state_q == S_IDLE) && (count_q == '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    lines_d = lines_q;
    hold_d  = hold_q;

    if (bus.push && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (push_ok) begin
      wptr_d = wptr_q + PTRW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTRW'(1);
      hold_d = mem_q[rptr_q];
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTRW + 1)'(1);
      2'b01:   count_d = count_q - (PTRW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  if (pop)           state_d = S_ISSUE;
      S_ISSUE: if (bus.rastReady) state_d = S_WAIT;
      S_WAIT:  if (bus.done)      state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase

    // frameDone only fires in IDLE and done only counts in WAIT, so these never collide.
    if (frame_done) begin
      lines_d = '0;
    end else if ((state_q == S_WAIT) && bus.done) begin
      lines_d = lines_q + CNTW'(1);
    end

    if (frame_done) begin
      pend_d = 1'b0;
    end else if (bus.frameEnd) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      lines_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      lines_q <= lines_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.full       = (count_q == FULL_CNT);
  assign bus.empty      = (count_q == '0);
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.frameDone  = frame_done;
  assign bus.linesDrawn = lines_q;
  assign bus.startX     = hold_q[CW-1:0];
  assign bus.endX       = hold_q[2*CW-1:CW];
  assign bus.startY     = hold_q[3*CW-1:2*CW];
  assign bus.endY       = hold_q[4*CW-1:3*CW];
  assign bus.lineColor  = hold_q[EW-1:4*CW];
  assign bus.readyIn    = (state_q == S_ISSUE);
endmodule

// File: tb/tb_line_dispatcher.sv
// Directed bench for line_dispatcher: single line, back-to-back issue, frame tracking,
// ISSUE stall, FIFO overflow and reset in the middle of a line.
module tb_line_dispatcher;
  localparam int DEPTH = 16;
  localparam int CW    = 13;
  localparam int CNTW  = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_lines;

  line_dispatcher_if #(.DEPTH(DEPTH), .CW(CW), .CNTW(CNTW)) bus ();

  line_dispatcher #(.DEPTH(DEPTH), .CW(CW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_line(input int sx, input int ex, input int sy, input int ey, input int col);
    bus.inStartX = CW'(sx);
    bus.inEndX   = CW'(ex);
    bus.inStartY = CW'(sy);
    bus.inEndY   = CW'(ey);
    bus.inColor  = 4'(col);
    bus.push     = 1'b1;
    step();
    bus.push     = 1'b0;
  endtask

  // Expects readyIn already high; checks the presented line, accepts it one cycle later.
  task automatic accept(input int sx, input int ex, input int sy, input int ey, input int col);
    check("readyIn_issue", bus.readyIn, 1);
    check("startX", bus.startX, sx);
    check("endX", bus.endX, ex);
    check("startY", bus.startY, sy);
    check("endY", bus.endY, ey);
    check("lineColor", bus.lineColor, col);
    step();
    check("readyIn_hold", bus.readyIn, 1);
    check("startX_hold", bus.startX, sx);
    bus.rastReady = 1'b1;
    step();
    bus.rastReady = 1'b0;
    check("readyIn_wait", bus.readyIn, 0);
  endtask

  task automatic finish_line(input int busy);
    repeat (busy) step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    exp_lines++;
    check("linesDrawn_done", bus.linesDrawn, exp_lines);
    check("readyIn_idle", bus.readyIn, 0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    errors = 0;
    checks = 0;
    exp_lines = 0;
    bus.push = 1'b0;
    bus.inStartX = '0;
    bus.inEndX = '0;
    bus.inStartY = '0;
    bus.inEndY = '0;
    bus.inColor = '0;
    bus.frameEnd = 1'b0;
    bus.rastReady = 1'b0;
    bus.done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_readyIn", bus.readyIn, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_linesDrawn", bus.linesDrawn, 0);
    check("rst_frameDone", bus.frameDone, 0);
    check("rst_startX", bus.startX, 0);
    check("rst_lineColor", bus.lineColor, 0);

    // Single line: readyIn two cycles after the push
    push_line(-10, 20, 5, -7, 7);
    check("t1_readyIn_early", bus.readyIn, 0);
    check("t1_count", bus.count, 1);
    check("t1_empty", bus.empty, 0);
    step();
    check("t1_count_popped", bus.count, 0);
    accept(-10, 20, 5, -7, 7);
    finish_line(30);

    // Back-to-back: queue three lines behind one in flight
    push_line(1, 2, 3, 4, 1);
    step();
    accept(1, 2, 3, 4, 1);
    push_line(11, -11, 12, -12, 2);
    push_line(21, -21, 22, -22, 3);
    push_line(31, -31, 32, -32, 4);
    check("t2_count3", bus.count, 3);
    finish_line(2);
    check("t2_count3_idle", bus.count, 3);
    step();
    check("t2_count2", bus.count, 2);
    accept(11, -11, 12, -12, 2);
    finish_line(3);
    step();
    check("t2_count1", bus.count, 1);
    accept(21, -21, 22, -22, 3);
    finish_line(1);
    step();
    check("t2_count0", bus.count, 0);
    accept(31, -31, 32, -32, 4);
    finish_line(2);

    // Frame end issued together with the second line's push
    push_line(100, 200, -100, -200, 9);
    bus.frameEnd = 1'b1;
    push_line(-300, 300, 50, -50, 10);
    bus.frameEnd = 1'b0;
    check("t3_frameDone_busy", bus.frameDone, 0);
    accept(100, 200, -100, -200, 9);
    finish_line(4);
    check("t3_frameDone_notempty", bus.frameDone, 0);
    step();
    check("t3_frameDone_issue", bus.frameDone, 0);
    accept(-300, 300, 50, -50, 10);
    finish_line(4);
    check("t3_frameDone_pulse", bus.frameDone, 1);
    exp_lines = 0;
    step();
    check("t3_frameDone_once", bus.frameDone, 0);
    check("t3_linesDrawn_clear", bus.linesDrawn, 0);
    step();
    check("t3_frameDone_quiet", bus.frameDone, 0);

    // Frame end with an empty queue
    bus.frameEnd = 1'b1;
    step();
    bus.frameEnd = 1'b0;
    check("t3_empty_frameDone", bus.frameDone, 1);
    step();
    check("t3_empty_frameDone_once", bus.frameDone, 0);

    // Stall in ISSUE with a spurious done
    push_line(-4096, 4095, 7, -1, 15);
    step();
    for (int i = 0; i < 50; i++) begin
      check("t4_stall_readyIn", bus.readyIn, 1);
      check("t4_stall_startX", bus.startX, -4096);
      check("t4_stall_endX", bus.endX, 4095);
      bus.done = (i == 20);
      step();
    end
    bus.done = 1'b0;
    check("t4_spurious_done", bus.linesDrawn, exp_lines);
    accept(-4096, 4095, 7, -1, 15);
    finish_line(5);

    // Overflow: fill behind a line in WAIT
    push_line(1, 2, 3, 4, 5);
    step();
    accept(1, 2, 3, 4, 5);
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_line(i - 8, 100 + i, -3 * i, 2 * i - 5, i);
      if (i == DEPTH - 1) begin
        check("t5_full_at_depth", bus.full, 1);
        check("t5_count_depth", bus.count, DEPTH);
        check("t5_no_overflow_yet", bus.overflow, 0);
      end
      if (i == DEPTH) begin
        check("t5_overflow_set", bus.overflow, 1);
        check("t5_count_held", bus.count, DEPTH);
      end
    end
    check("t5_count_final", bus.count, DEPTH);
    finish_line(2);
    // Pop and a push into a full FIFO in the same cycle: the push is still dropped
    bus.inStartX = CW'(99);
    bus.inColor  = 4'hf;
    bus.push     = 1'b1;
    step();
    bus.push     = 1'b0;
    check("t5_push_pop_full", bus.count, DEPTH - 1);
    check("t5_full_cleared", bus.full, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) step();
      check("t5_drain_count", bus.count, DEPTH - 1 - i);
      accept(i - 8, 100 + i, -3 * i, 2 * i - 5, i);
      finish_line(1);
    end
    step();
    check("t5_no_extra_line", bus.readyIn, 0);
    check("t5_drained_empty", bus.empty, 1);
    check("t5_overflow_sticky", bus.overflow, 1);

    // Reset while a line is in WAIT with five queued
    push_line(7, 8, 9, 10, 11);
    step();
    accept(7, 8, 9, 10, 11);
    for (int i = 0; i < 5; i++) begin
      bus.frameEnd = (i == 4);
      push_line(i, i, i, i, i);
    end
    bus.frameEnd = 1'b0;
    check("t6_count5", bus.count, 5);
    check("t6_linesDrawn_pre", bus.linesDrawn, exp_lines);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_lines = 0;
    check("t6_readyIn", bus.readyIn, 0);
    check("t6_count", bus.count, 0);
    check("t6_empty", bus.empty, 1);
    check("t6_overflow", bus.overflow, 0);
    check("t6_linesDrawn", bus.linesDrawn, 0);
    check("t6_frameDone", bus.frameDone, 0);
    check("t6_startX", bus.startX, 0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("t6_done_idle_ignored", bus.linesDrawn, 0);
    check("t6_frameDone_after", bus.frameDone, 0);
    step();
    check("t6_queue_discarded", bus.readyIn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_dispatcher.md
Name: line_dispatcher

Overview:
- Command-side initiator for the line rasterizer.
- Buffers line commands (endpoints plus colour) produced by the vector-generator front end in a FIFO.
- Issues them one at a time to the rasterizer over the readyIn/rastReady/done handshake, and never issues a new line until the previous line's done pulse.
- Tracks frame completion so the frame-buffer swap logic knows when every queued line has been drawn.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CW, 13, signed coordinate width; matches the rasterizer's startX/endX/startY/endY.
- CNTW, 16, width of the lines-drawn counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- push  in  1  enqueue one line command this cycle.
- inStartX, inEndX, inStartY, inEndY  in  CW each  signed line endpoints.
- inColor  in  4  line colour.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  log2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a push was dropped.
- frameEnd  in  1  pulse: no more lines follow for this frame.
- frameDone  out  1  one-cycle pulse when the frame has fully drained.
- linesDrawn  out  CNTW  lines completed since the last frameDone.
- startX, endX, startY, endY  out  CW each  endpoints presented to the rasterizer.
- lineColor  out  4  colour presented to the rasterizer.
- readyIn  out  1  a line is presented and valid.
- rastReady  in  1  rasterizer is idle.
- done  in  1  rasterizer one-cycle line-complete pulse.

Behaviour:
- Reset state: FIFO emptied, state=IDLE, all outputs 0, empty=1, overflow=0, linesDrawn=0, frame-pending flag cleared.
- Reset mid-line discards the held line and the whole queue; there is no recovery handshake, because the rasterizer shares rst.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - A push while full is dropped, sets overflow, and leaves contents unchanged. This applies even if a pop happens in the same cycle.
  - A push and a pop in the same non-full cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Output hold registers: startX..lineColor are registered. They load from the FIFO head on the pop cycle and hold until the next pop.
- State IDLE:
  - readyIn=0.
  - If count>0: load hold registers from head, pop, go to ISSUE.
  - A push into an empty FIFO at edge t makes readyIn high after edge t+2.
- State ISSUE:
  - readyIn=1, decoded from state; outputs are stable throughout.
  - If rastReady=1 this cycle: the rasterizer latches at this edge; go to WAIT.
  - Otherwise stay in ISSUE indefinitely.
- State WAIT:
  - readyIn=0.
  - On done=1: linesDrawn increments (wraps at 2^CNTW), go to IDLE.
  - done in any other state is ignored and does not count.
- Back-to-back throughput: done(t) leads to IDLE at t+1, pop, and ISSUE at t+2. A minimum of 2 idle cycles between lines is accepted.
- Frame tracking:
  - frameEnd sets framePending.
  - frameDone pulses for exactly one cycle when framePending=1, state=IDLE, and count=0 in the same cycle. That same cycle clears framePending.
  - linesDrawn resets to 0 on the cycle after the frameDone pulse.
  - frameEnd while framePending is already set has no extra effect.
  - frameEnd with an empty queue in IDLE gives frameDone on the next cycle.
  - frameEnd arriving in the same cycle as a push: that pushed line belongs to the current frame.
- Arithmetic: coordinates pass through unmodified; no clipping or offsetting. The rasterizer applies its own offsets.

Test Plan:
- Single line:
  - Stimulus: after reset, push (-10,5)->(20,-7), colour 4'h7; rasterizer model asserts rastReady 1 cycle after readyIn and pulses done 31 cycles later.
  - Required: readyIn rises 2 cycles after push; outputs equal -10, 20, 5, -7, 7 while readyIn=1; linesDrawn=1 after done.
- Back-to-back:
  - Stimulus: push 3 lines in consecutive cycles; model pulses done each time.
  - Required: lines issued in push order; exactly 2 cycles from each done to the next readyIn; count goes 3->2->1->0.
- Overflow:
  - Stimulus: rastReady held 0; push DEPTH+2 lines.
  - Required: full=1 at count=16; overflow=1; the 17th and 18th pushes are dropped; after releasing rastReady, exactly 16 lines are issued.
- Frame end:
  - Stimulus: push 2 lines, pulse frameEnd.
  - Required: frameDone pulses exactly once, 1 cycle after the second line's done (IDLE with empty FIFO); linesDrawn=2 on that cycle and 0 on the next.
- Stall in ISSUE:
  - Stimulus: rastReady=0 for 50 cycles.
  - Required: readyIn stays 1 and outputs stay constant for all 50 cycles; a spurious done during ISSUE does not change linesDrawn.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT with 5 lines queued.
  - Required: next cycle readyIn=0, count=0, empty=1, overflow=0, linesDrawn=0, no frameDone.
